// File: rtl/button_event_reader.sv
// ============================================================================
// Module      : button_event_reader
// Description : Three-button front end. Each raw button is synchronized and
//               debounced; every debounced level change becomes a
//               {press/release, index} event in a small FWFT queue. A sticky
//               overflow flag records events lost to back-pressure.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module button_event_reader #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic [2:0]                   btn_in,
    output logic [2:0]                   btn_state,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [2:0]                   evt_data,
    output logic [$clog2(FIFO_DEPTH):0]  evt_count,
    output logic                         overflow,
    input  logic                         clr_overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    // Debounced levels and the one-cycle toggle strobes they generate
    logic [2:0] state_vec;
    logic [2:0] toggle;

    // ------------------------------------------------------------------------
    // Per-button synchronizer and debouncer
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             state_q, state_d;

        // A change is accepted only on the DEBOUNCE_CYCLES-th consecutive
        // cycle of disagreement; any agreeing cycle restarts the count.
        assign toggle[i]    = (sync2_q != state_q) && (cnt_q == CNT_LAST);
        assign state_vec[i] = state_q;

        // Next-state for synchronizer, counter and debounced level
        always_comb begin
            sync1_d = btn_in[i];
            sync2_d = sync1_q;
            state_d = state_q ^ toggle[i];
            cnt_d   = '0;
            if ((sync2_q != state_q) && !toggle[i]) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Register synchronizer, counter and debounced level
        always_ff @(posedge CLK) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                cnt_q   <= '0;
                state_q <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                cnt_q   <= cnt_d;
                state_q <= state_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pending events, arbiter and queue
    // ------------------------------------------------------------------------
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       kind_q, kind_d;
    logic             overflow_q, overflow_d;
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [2:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    logic [2:0]       push_sel;
    logic [1:0]       push_idx;
    logic [2:0]       pushed;
    logic             push_en;
    logic             pop_en;
    logic             lost;

    // Pick the lowest pending button, push it if there is room, update the
    // pending/kind bookkeeping and the queue pointers
    always_comb begin
        push_sel = 3'b000;
        push_idx = 2'd0;
        if (pending_q[0]) begin
            push_sel = 3'b001;
            push_idx = 2'd0;
        end else if (pending_q[1]) begin
            push_sel = 3'b010;
            push_idx = 2'd1;
        end else if (pending_q[2]) begin
            push_sel = 3'b100;
            push_idx = 2'd2;
        end

        pop_en  = (count_q != '0) && evt_ready;
        push_en = (|pending_q) && ((count_q != OCC_FULL) || pop_en);
        pushed  = push_en ? push_sel : 3'b000;

        // A toggle on a button whose event is still waiting (and not leaving
        // this cycle) replaces that event, so the older one is lost.
        lost      = |(toggle & pending_q & ~pushed);
        pending_d = (pending_q & ~pushed) | toggle;
        kind_d    = (kind_q & ~toggle) | (~state_vec & toggle);

        if (lost) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        mem_d = mem_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = {|(kind_q & push_sel), push_idx};
        end
        wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Register event bookkeeping and queue state
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            pending_q  <= '0;
            kind_q     <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            pending_q  <= pending_d;
            kind_q     <= kind_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign btn_state = state_vec;
    assign evt_valid = (count_q != '0);
    assign evt_data  = mem_q[rd_ptr_q];
    assign evt_count = count_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_button_event_reader.sv
// ============================================================================
// Module      : tb_button_event_reader
// Description : Self-checking bench for button_event_reader: directed vector
//               table, hand-written corner sequences and a randomized run
//               checked every cycle against a behavioural event model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_event_reader;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn_in = 3'b000;
    logic [2:0] btn_state;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [2:0] evt_data;
    logic [2:0] evt_count;
    logic       overflow;
    logic       clr_overflow = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    button_event_reader #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .btn_state   (btn_state),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_data    (evt_data),
        .evt_count   (evt_count),
        .overflow    (overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Behavioural model: delayed samples, run lengths of disagreement,
    // a list of outstanding events and a list-based queue.
    // ------------------------------------------------------------------
    bit [2:0] m_s1, m_s2, m_st, m_pend, m_kind;
    int       m_run [3];
    bit       m_ovf;
    bit [2:0] m_q [$];

    task automatic model_edge(input bit [2:0] b, input bit rdy, input bit clr, input bit rstn);
        bit [2:0] tog;
        bit       was_full;
        bit       pop;
        int       pushed;
        bit       lost;
        if (!rstn) begin
            m_s1 = 0; m_s2 = 0; m_st = 0; m_pend = 0; m_kind = 0; m_ovf = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_q = {};
            return;
        end
        tog = 0;
        for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_st[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    tog[i]   = 1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
        was_full = (m_q.size() == DEPTH);
        pop      = (m_q.size() != 0) && rdy;
        if (pop) void'(m_q.pop_front());
        pushed = -1;
        for (int i = 0; i < 3; i++) begin
            if (pushed < 0 && m_pend[i]) begin
                if (!was_full || pop) begin
                    m_q.push_back({m_kind[i], 2'(i)});
                    m_pend[i] = 0;
                    pushed    = i;
                end else begin
                    pushed = 99;  // head-of-line blocked, nothing moves
                end
            end
        end
        lost = 0;
        for (int i = 0; i < 3; i++) begin
            if (tog[i]) begin
                if (m_pend[i]) lost = 1;
                m_pend[i] = 1;
                m_kind[i] = ~m_st[i];
                m_st[i]   = ~m_st[i];
            end
        end
        if (lost)      m_ovf = 1;
        else if (clr)  m_ovf = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_btn_state", 32'(btn_state), 32'(m_st));
        chk("model_evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
        chk("model_evt_count", 32'(evt_count), 32'(m_q.size()));
        chk("model_overflow",  32'(overflow),  32'(m_ovf));
        if (m_q.size() != 0) chk("model_evt_data", 32'(evt_data), 32'(m_q[0]));
    endtask

    // One clock: drive away from the edge, clock, update model, sample.
    task automatic cyc(input bit [2:0] b, input bit rdy, input bit clr, input bit rstn);
        @(negedge CLK);
        btn_in       = b;
        evt_ready    = rdy;
        clr_overflow = clr;
        rst_n        = rstn;
        @(posedge CLK);
        model_edge(b, rdy, clr, rstn);
        #1;
        check_model();
    endtask

    typedef struct {
        bit [2:0] btn;
        bit       rdy;
        bit [2:0] st;
        bit       vld;
        bit [2:0] cnt;
        bit [2:0] dat;
    } vec_t;

    vec_t     tbl [17];
    bit [2:0] drain_exp [5];
    bit [2:0] b;
    bit       rdy;
    bit       found;

    initial begin
        // Directed vectors: press of button 0, pop, release, pop
        for (int r = 0; r < 17; r++) begin
            tbl[r].btn = (r < 9) ? 3'b001 : 3'b000;
            tbl[r].rdy = (r >= 8);
            tbl[r].st  = (r >= 5 && r < 14) ? 3'b001 : 3'b000;
            tbl[r].vld = (r == 6 || r == 7 || r == 15);
            tbl[r].cnt = tbl[r].vld ? 3'd1 : 3'd0;
            tbl[r].dat = (r == 15) ? 3'b000 : 3'b100;
        end

        cyc(3'b000, 0, 0, 0);
        cyc(3'b000, 0, 0, 0);
        chk("reset_btn_state", 32'(btn_state), 0);
        chk("reset_evt_valid", 32'(evt_valid), 0);
        chk("reset_evt_count", 32'(evt_count), 0);
        chk("reset_evt_data",  32'(evt_data),  0);
        chk("reset_overflow",  32'(overflow),  0);

        for (int r = 0; r < 17; r++) begin
            cyc(tbl[r].btn, tbl[r].rdy, 0, 1);
            chk($sformatf("tbl%0d_state", r), 32'(btn_state), 32'(tbl[r].st));
            chk($sformatf("tbl%0d_valid", r), 32'(evt_valid), 32'(tbl[r].vld));
            chk($sformatf("tbl%0d_count", r), 32'(evt_count), 32'(tbl[r].cnt));
            if (tbl[r].vld) chk($sformatf("tbl%0d_data", r), 32'(evt_data), 32'(tbl[r].dat));
        end

        // Short glitch on button 1 is filtered
        for (int k = 0; k < 14; k++) begin
            cyc((k < 3) ? 3'b010 : 3'b000, 0, 0, 1);
            chk("glitch_state", 32'(btn_state), 0);
            chk("glitch_valid", 32'(evt_valid), 0);
        end

        // All three pressed together, consumer always ready
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc(3'b111, 1, 0, 1);
            found = evt_valid;
        end
        chk("all3_valid_seen", 32'(found), 1);
        chk("all3_first", 32'(evt_data), 32'(3'b100));
        cyc(3'b111, 1, 0, 1);
        chk("all3_second", 32'(evt_data), 32'(3'b101));
        cyc(3'b111, 1, 0, 1);
        chk("all3_third", 32'(evt_data), 32'(3'b110));
        chk("all3_overflow", 32'(overflow), 0);
        for (int k = 0; k < 3; k++) cyc(3'b111, 1, 0, 1);
        chk("all3_drained", 32'(evt_count), 0);

        // Six toggles of button 0 with no consumer: full queue, then loss
        cyc(3'b000, 0, 0, 0);
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 8; k++) cyc((t % 2 == 0) ? 3'b001 : 3'b000, 0, 0, 1);
        end
        chk("ovf_full_count", 32'(evt_count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        cyc(3'b000, 0, 1, 1);
        chk("ovf_cleared", 32'(overflow), 0);
        drain_exp = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b000};
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(evt_valid), 1);
            chk($sformatf("drain%0d_data", k), 32'(evt_data), 32'(drain_exp[k]));
            cyc(3'b000, 1, 0, 1);
            if (k == 0) chk("full_pop_push_count", 32'(evt_count), 4);
        end
        chk("drain_empty", 32'(evt_count), 0);
        chk("drain_no_ovf", 32'(overflow), 0);

        // Reset with three queued events
        cyc(3'b000, 0, 0, 0);
        for (int k = 0; k < 10; k++) cyc(3'b111, 0, 0, 1);
        chk("pre_reset_count", 32'(evt_count), 3);
        cyc(3'b000, 0, 0, 0);
        chk("midrst_valid", 32'(evt_valid), 0);
        chk("midrst_count", 32'(evt_count), 0);
        chk("midrst_overflow", 32'(overflow), 0);
        chk("midrst_state", 32'(btn_state), 0);

        // Buttons held through reset release report as normal presses
        cyc(3'b111, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            cyc(3'b111, 0, 0, 1);
            if (k == 5) chk("held_rst_before", 32'(btn_state), 0);
            if (k == 6) chk("held_rst_rise", 32'(btn_state), 32'(3'b111));
        end

        // Randomized run against the model
        b = 3'b000;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
            end
            if ((n / 200) % 2 == 0) rdy = ($urandom_range(0, 3) == 0);
            else                    rdy = ($urandom_range(0, 3) != 0);
            cyc(b, rdy, ($urandom_range(0, 19) == 0), ($urandom_range(0, 499) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
